// File: rtl/rst_sequencer.sv
// Reset sequencer: async assertion, synchronised deassertion, hold-off, then staggered
// per-domain release. A software/debug request re-resets every domain except domain 0.
module rst_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int HOLD_CYCLES  = 16,
  parameter int NUM_DOMAINS  = 3,
  parameter int STAGE_GAP    = 4,
  parameter int SWRST_CYCLES = 8
) (
  input  logic                   clk_sys,
  input  logic                   rst_sys_n,
  input  logic                   ext_rst_req_i,
  output logic [NUM_DOMAINS-1:0] rst_domain_no,
  output logic                   rst_done_o,
  output logic [1:0]             rst_cause_o
);

  localparam int MAX_HG = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_C  = (MAX_HG > SWRST_CYCLES) ? MAX_HG : SWRST_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam int IW     = $clog2(NUM_DOMAINS);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] SW_LEN    = CW'(SWRST_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

  localparam logic [2:0] S_RESET   = 3'd0;
  localparam logic [2:0] S_HOLD    = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_SWRST   = 3'd4;

  localparam logic [1:0] CAUSE_POR = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  if (SYNC_STAGES < 2)  begin : g_chk_sync  $error("SYNC_STAGES must be >= 2");  end
  if (HOLD_CYCLES < 1)  begin : g_chk_hold  $error("HOLD_CYCLES must be >= 1");  end
  if (NUM_DOMAINS < 2)  begin : g_chk_dom   $error("NUM_DOMAINS must be >= 2");  end
  if (STAGE_GAP < 1)    begin : g_chk_gap   $error("STAGE_GAP must be >= 1");    end
  if (SWRST_CYCLES < 1) begin : g_chk_swrst $error("SWRST_CYCLES must be >= 1"); end

  logic [2:0]             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   done_q, done_d;
  logic [1:0]             cause_q, cause_d;

  // HOLD is entered on the same edge the synchroniser output first reads 1, so domain 0
  // lands exactly SYNC_STAGES+HOLD_CYCLES edges after the raw reset is first sampled high.
  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = done_q;
    cause_d = cause_q;
    case (state_q)
      S_RESET: begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
        cnt_d  = '0;
        if (sync_d[SYNC_STAGES-1]) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d  = S_RELEASE;
          cnt_d    = '0;
          idx_d    = '0;
          dom_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_RUN;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d        = '0;
          idx_d        = idx_q + 1'b1;
          dom_d[idx_d] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (ext_rst_req_i) begin
          state_d                  = S_SWRST;
          dom_d[NUM_DOMAINS-1:1]   = '0;
          done_d                   = 1'b0;
          cause_d                  = CAUSE_SW;
          cnt_d                    = '0;
        end
      end
      S_SWRST: begin
        // Counter saturates at the minimum length, then release waits for the request to drop.
        if (cnt_q != SW_LEN) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!ext_rst_req_i) begin
          state_d  = S_RELEASE;
          cnt_d    = '0;
          idx_d    = IDX_ONE;
          dom_d[1] = 1'b1;
        end
      end
      default: begin
        state_d = S_RESET;
        dom_d   = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= S_RESET;
      sync_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  assign rst_domain_no = dom_q;
  assign rst_done_o    = done_q;
  assign rst_cause_o   = cause_q;

endmodule
